// File: rtl/dram_rr_scheduler.sv
// Round-robin arbiter that lends the single burst DRAM to one of NUM_REQ requesters
// at a time, sequencing the access and reporting completion or error to the owner.
module dram_rr_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 8,
  parameter int BEAT_W         = 16,
  parameter int BURST_BEATS    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*BEAT_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           wr_pop,
  output logic                         rd_valid,
  output logic [BEAT_W-1:0]            rd_data,
  output logic [$clog2(NUM_REQ)-1:0]   rd_id,
  output logic                         done,
  output logic [$clog2(NUM_REQ)-1:0]   done_id,
  output logic                         done_err,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_read_en,
  output logic                         mem_write_en,
  output logic [BEAT_W-1:0]            mem_wdata,
  input  logic                         mem_ready,
  input  logic                         mem_complete,
  input  logic                         mem_valid,
  input  logic [BEAT_W-1:0]            mem_rdata
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BURST_BEATS + 2);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_ERR,
    S_DRAIN
  } state_t;

  state_t             state_q;
  logic [IDW-1:0]     idx_q;
  logic               op_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [CW-1:0]      beat_q;
  logic [TW-1:0]      tmo_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               rd_en_q;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               done_q;
  logic [IDW-1:0]     done_id_q;
  logic               done_err_q;
  logic               rd_valid_q;
  logic [BEAT_W-1:0]  rd_data_q;
  logic [IDW-1:0]     rd_id_q;

  logic               pick_ok;
  logic [IDW-1:0]     pick_idx;
  logic [IDW-1:0]     cand_idx;
  logic [CW-1:0]      beat_d;
  logic [IDW-1:0]     rr_ptr_d;

  // First asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_ok && req[cand_idx]) begin
        pick_ok  = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // Saturating beat count including a beat that lands alongside mem_complete.
  always_comb begin
    beat_d = beat_q;
    if (mem_valid && (beat_q != '1)) beat_d = beat_q + CW'(1);
  end

  always_comb begin
    rr_ptr_d = (idx_q == IDW'(NUM_REQ - 1)) ? '0 : idx_q + IDW'(1);
  end

  always_comb begin
    wr_pop    = '0;
    mem_wdata = '0;
    if (state_q == S_BUSY && op_q) begin
      mem_wdata = req_wdata[32'(idx_q)*BEAT_W +: BEAT_W];
      if (mem_valid) wr_pop[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      op_q       <= 1'b0;
      rr_ptr_q   <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      gnt_q      <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      done_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_ok && mem_ready) begin
            idx_q   <= pick_idx;
            op_q    <= req_we[pick_idx];
            addr_q  <= req_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
            gnt_q   <= NUM_REQ'(1) << pick_idx;
            rd_en_q <= !req_we[pick_idx];
            wr_en_q <= req_we[pick_idx];
            beat_q  <= '0;
            tmo_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          beat_q     <= beat_d;
          tmo_q      <= tmo_q + TW'(1);
          rd_valid_q <= mem_valid && !op_q;
          rd_data_q  <= mem_rdata;
          rd_id_q    <= idx_q;
          if (mem_complete) begin
            state_q    <= S_DONE;
            gnt_q      <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b1;
            done_id_q  <= idx_q;
            done_err_q <= (beat_d != CW'(BURST_BEATS));
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= S_ERR;
            gnt_q      <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b1;
            done_id_q  <= idx_q;
            done_err_q <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= S_DRAIN;
        end
        S_DRAIN: begin
          if (mem_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_id        = rd_id_q;
  assign done         = done_q;
  assign done_id      = done_id_q;
  assign done_err     = done_err_q;
  assign mem_addr     = addr_q;
  assign mem_read_en  = rd_en_q;
  assign mem_write_en = wr_en_q;

endmodule

// File: tb/tb_dram_rr_scheduler.sv
// Scoreboard bench for dram_rr_scheduler with a behavioural burst DRAM model;
// stimulus queues expected grants, read beats and completions for a monitor.
module tb_dram_rr_scheduler;

  localparam int NR  = 4;
  localparam int AW  = 8;
  localparam int BW  = 16;
  localparam int BB  = 4;
  localparam int TO  = 256;
  localparam int IDW = 2;

  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_BEAT = 2;
  localparam int M_CMP  = 3;
  localparam int M_PRE  = 4;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*BW-1:0] req_wdata;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    wr_pop;
  logic             rd_valid;
  logic [BW-1:0]    rd_data;
  logic [IDW-1:0]   rd_id;
  logic             done;
  logic [IDW-1:0]   done_id;
  logic             done_err;
  logic [AW-1:0]    mem_addr;
  logic             mem_read_en;
  logic             mem_write_en;
  logic [BW-1:0]    mem_wdata;
  logic             mem_ready;
  logic             mem_complete;
  logic             mem_valid;
  logic [BW-1:0]    mem_rdata;

  dram_rr_scheduler #(
    .NUM_REQ(NR), .ADDR_W(AW), .BEAT_W(BW), .BURST_BEATS(BB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .wr_pop(wr_pop), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_id(rd_id), .done(done), .done_id(done_id),
    .done_err(done_err), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_complete(mem_complete), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int id; logic [BW-1:0] data; } rd_exp_t;
  typedef struct { int id; logic err; } done_exp_t;

  int        total = 0;
  int        bad   = 0;
  int        exp_gnt[$];
  rd_exp_t   exp_rd[$];
  done_exp_t exp_done[$];
  int        gnt_seen  = 0;
  int        done_seen = 0;
  int        ndone_exp = 0;

  logic [BW-1:0] dmem [0:255][0:BB-1];
  logic [BW-1:0] wpat [0:BB-1];
  int            wptr = 0;
  int            pop_cnt [0:NR-1];
  logic          stall = 1'b0;
  logic          short_mode = 1'b0;
  logic          force_nr = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pat(input int a, input int b);
    return BW'(32'hA000 ^ (a << 4) ^ b);
  endfunction

  // Burst DRAM model: two-cycle activate, BB beats, one complete pulse, precharge.
  initial begin
    int mst;
    int mcnt;
    int mbeat;
    int nb;
    logic en;
    mst = M_IDLE; mcnt = 0; mbeat = 0;
    mem_ready = 1'b1; mem_valid = 1'b0; mem_complete = 1'b0; mem_rdata = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) pop_cnt[i] = 0;
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < BB; b++) dmem[a][b] = pat(a, b);
    forever begin
      @(negedge clk);
      if (mem_valid && mem_write_en) dmem[mem_addr][mbeat] = mem_wdata;
      for (int i = 0; i < NR; i++) if (wr_pop[i]) pop_cnt[i]++;
      if (wr_pop[1]) begin
        wptr++;
        req_wdata[BW +: BW] = (wptr < BB) ? wpat[wptr] : '0;
      end
      en = mem_read_en | mem_write_en;
      nb = short_mode ? BB - 1 : BB;
      case (mst)
        M_IDLE: begin
          mem_ready = !force_nr;
          if (en) begin mem_ready = 1'b0; mst = M_ACT; mcnt = 0; end
        end
        M_ACT: begin
          if (!en) begin mem_valid = 1'b0; mem_complete = 1'b0; mst = M_PRE; end
          else if (!stall) begin
            mcnt++;
            if (mcnt == 2) begin
              mbeat = 0; mem_valid = 1'b1; mem_rdata = dmem[mem_addr][0]; mst = M_BEAT;
            end
          end
        end
        M_BEAT: begin
          if (!en) begin mem_valid = 1'b0; mem_complete = 1'b0; mst = M_PRE; end
          else begin
            mbeat++;
            if (mbeat < nb) mem_rdata = dmem[mem_addr][mbeat];
            else begin mem_valid = 1'b0; mem_complete = 1'b1; mst = M_CMP; end
          end
        end
        M_CMP: begin mem_complete = 1'b0; mst = M_PRE; end
        default: if (!en) begin mem_ready = !force_nr; mst = M_IDLE; end
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a grant, beat or completion.
  initial begin
    logic [NR-1:0] prev_gnt;
    int e;
    rd_exp_t r;
    done_exp_t d;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (gnt != '0 && prev_gnt == '0) begin
          gnt_seen++;
          if (exp_gnt.size() == 0) check("unexpected gnt", 64'(gnt), 64'(0));
          else begin
            e = exp_gnt.pop_front();
            check("gnt", 64'(gnt), 64'(1) << e);
          end
        end
        if (rd_valid) begin
          if (exp_rd.size() == 0) check("unexpected rd_valid", 64'(rd_data), 64'(0));
          else begin
            r = exp_rd.pop_front();
            check("rd_id", 64'(rd_id), 64'(r.id));
            check("rd_data", 64'(rd_data), 64'(r.data));
          end
        end
        if (done) begin
          done_seen++;
          check("enables at done", 64'({mem_read_en, mem_write_en}), 64'(0));
          check("gnt at done", 64'(gnt), 64'(0));
          if (exp_done.size() == 0) check("unexpected done", 64'(done_id), 64'(0));
          else begin
            d = exp_done.pop_front();
            check("done_id", 64'(done_id), 64'(d.id));
            check("done_err", 64'(done_err), 64'(d.err));
          end
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_gnt(input int target);
    int n;
    n = 0;
    while (gnt_seen < target && n < 2000) begin @(negedge clk); n++; end
    if (gnt_seen < target) check("gnt wait", 64'(gnt_seen), 64'(target));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 2000) begin @(negedge clk); n++; end
    if (done_seen < target) check("done wait", 64'(done_seen), 64'(target));
  endtask

  task automatic expect_access(input int id, input int addr, input int beats, input logic err,
                               input logic use_wpat);
    rd_exp_t r;
    done_exp_t d;
    exp_gnt.push_back(id);
    for (int b = 0; b < beats; b++) begin
      r.id = id;
      r.data = use_wpat ? wpat[b] : pat(addr, b);
      exp_rd.push_back(r);
    end
    d.id = id; d.err = err;
    exp_done.push_back(d);
    ndone_exp++;
  endtask

  task automatic issue(input int i, input logic we, input int a);
    int g;
    g = gnt_seen;
    req_we[i] = we;
    req_addr[i*AW +: AW] = AW'(a);
    req[i] = 1'b1;
    wait_gnt(g + 1);
    req[i] = 1'b0;
  endtask

  initial begin
    int n;
    int g;
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0;
    wpat[0] = 16'hC0DE; wpat[1] = 16'hBEEF; wpat[2] = 16'h1234; wpat[3] = 16'h5A5A;
    repeat (3) @(negedge clk);
    check("reset gnt", 64'(gnt), 64'(0));
    check("reset done", 64'({done, done_err}), 64'(0));
    check("reset rd_valid", 64'(rd_valid), 64'(0));
    check("reset enables", 64'({mem_read_en, mem_write_en}), 64'(0));
    check("reset wr_pop", 64'(wr_pop), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single read from requester 2
    expect_access(2, 5, BB, 1'b0, 1'b0);
    issue(2, 1'b0, 5);
    wait_done(ndone_exp);

    // Write from requester 1, then read it back
    for (int i = 0; i < NR; i++) pop_cnt[i] = 0;
    wptr = 0;
    req_wdata[BW +: BW] = wpat[0];
    exp_gnt.push_back(1);
    begin
      done_exp_t d;
      d.id = 1; d.err = 1'b0;
      exp_done.push_back(d);
      ndone_exp++;
    end
    issue(1, 1'b1, 9);
    wait_done(ndone_exp);
    check("wr_pop[1] count", 64'(pop_cnt[1]), 64'(BB));
    check("wr_pop other", 64'(pop_cnt[0] + pop_cnt[2] + pop_cnt[3]), 64'(0));
    for (int b = 0; b < BB; b++) check("dram write beat", 64'(dmem[9][b]), 64'(wpat[b]));
    expect_access(1, 9, BB, 1'b0, 1'b1);
    issue(1, 1'b0, 9);
    wait_done(ndone_exp);

    // Stalled DRAM: abort after TIMEOUT_CYCLES busy cycles
    stall = 1'b1;
    exp_gnt.push_back(3);
    begin
      done_exp_t d;
      d.id = 3; d.err = 1'b1;
      exp_done.push_back(d);
      ndone_exp++;
    end
    req_we[3] = 1'b0; req_addr[3*AW +: AW] = 8'd7; req[3] = 1'b1;
    n = 0;
    while (gnt == '0 && n < 100) begin @(negedge clk); n++; end
    req[3] = 1'b0;
    n = 1;
    while (n <= TO + 10) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    check("timeout busy cycles", 64'(n), 64'(TO));
    check("done_err on timeout", 64'(done_err), 64'(1));
    @(negedge clk);
    check("enables after err", 64'({mem_read_en, mem_write_en}), 64'(0));
    stall = 1'b0;
    wait_done(ndone_exp);

    // Reset during BUSY: immediate clear, no completion
    exp_gnt.push_back(2);
    req_we[2] = 1'b0; req_addr[2*AW +: AW] = 8'd5; req[2] = 1'b1;
    n = 0;
    while (gnt == '0 && n < 100) begin @(negedge clk); n++; end
    #1 rst = 1'b1;
    #1;
    check("async rst gnt", 64'(gnt), 64'(0));
    check("async rst enables", 64'({mem_read_en, mem_write_en}), 64'(0));
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no done after rst", 64'(done_seen), 64'(ndone_exp));

    // All four requesting: 0,1,2,3, then 0 again
    for (int k = 0; k < 5; k++) expect_access(k % NR, 16 + (k % NR), BB, 1'b0, 1'b0);
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(16 + i);
    req_we = '0;
    g = gnt_seen;
    req = 4'hF;
    wait_gnt(g + 5);
    req = '0;
    wait_done(ndone_exp);

    // No grant while mem_ready is low
    force_nr = 1'b1;
    repeat (3) @(negedge clk);
    expect_access(0, 3, BB, 1'b0, 1'b0);
    g = gnt_seen;
    req_we[0] = 1'b0; req_addr[0 +: AW] = 8'd3; req[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("gnt while not ready", 64'(gnt), 64'(0));
    force_nr = 1'b0;
    wait_gnt(g + 1);
    req[0] = 1'b0;
    wait_done(ndone_exp);

    // Short burst: beat-count mismatch flagged
    short_mode = 1'b1;
    expect_access(2, 5, BB - 1, 1'b1, 1'b0);
    issue(2, 1'b0, 5);
    wait_done(ndone_exp);
    short_mode = 1'b0;

    repeat (5) @(negedge clk);
    check("gnt left", 64'(exp_gnt.size()), 64'(0));
    check("rd left", 64'(exp_rd.size()), 64'(0));
    check("done left", 64'(exp_done.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
